// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between a requester and the serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that time-shares one external decoder-based full-adder slice,
// LSB first, with a carry register and a direct-sum cross-check of the slice result.
module serial_adder_ctrl #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus,
  output logic                fa_a,
  output logic                fa_b,
  output logic                fa_ci,
  output logic [2:0]          fa_en,
  input  logic                fa_s,
  input  logic                fa_co
);

  localparam int DEPTH = 1 << IDXW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] ra_reg, rb_reg;
  logic [WIDTH-1:0] sumr_reg, sumr_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, err_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             last_bit;

  // Operands widened to the full index range so idx can select a bit directly.
  logic [DEPTH-1:0] ra_ext, rb_ext;
  assign ra_ext = DEPTH'(ra_reg);
  assign rb_ext = DEPTH'(rb_reg);

  assign last_bit = (idx_reg == IDXW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_ci      = 1'b0;
    fa_en      = 3'b011;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) state_next = ST_RUN;
      end
      ST_RUN: begin
        fa_a  = ra_ext[idx_reg];
        fa_b  = rb_ext[idx_reg];
        fa_ci = carry_reg;
        fa_en = 3'b100;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Slice sum lands in the bit position currently addressed by idx.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_bit
      assign sumr_next[gi] = (idx_reg == IDXW'(gi)) ? fa_s : sumr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_reg    <= '0;
      rb_reg    <= '0;
      sumr_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            ra_reg    <= bus.a;
            rb_reg    <= bus.b;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          sumr_reg  <= sumr_next;
          carry_reg <= fa_co;
          idx_reg   <= idx_reg + IDXW'(1);
          // Publish the result and the cross-check on the edge entering DONE.
          if (last_bit) begin
            sum_reg  <= sumr_next;
            cout_reg <= fa_co;
            err_reg  <= ({fa_co, sumr_next} != ({1'b0, ra_reg} + {1'b0, rb_reg}));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == ST_RUN);
  assign bus.done = (state_reg == ST_DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural adder slice that can inject a stuck-at-0 sum.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fa_a, fa_b, fa_ci;
  logic [2:0] fa_en;
  logic       fa_s, fa_co;
  logic       fault_en = 1'b0;
  int         bit_cnt = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH), .IDXW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_en (fa_en),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  always #5 clk = ~clk;

  // Slice model: RUN cycle k processes bit k; the fault forces bit 1's sum low.
  always @(posedge clk) begin
    if (!bus.busy) bit_cnt <= 0;
    else           bit_cnt <= bit_cnt + 1;
  end

  assign fa_s  = (fault_en && bit_cnt == 1) ? 1'b0 : (fa_a ^ fa_b ^ fa_ci);
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests_run++; if (bus.sum !== 4'h0) begin tests_failed++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    tests_run++; if (fa_en !== 3'b011) begin tests_failed++; $display("FAIL reset_fa_en got=%b exp=011", fa_en); end
    tests_run++; if ({fa_a, fa_b, fa_ci} !== 3'b000) begin tests_failed++; $display("FAIL reset_fa_abc got=%b exp=000", {fa_a, fa_b, fa_ci}); end
    rst = 1'b0;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_add();
    logic [3:0] ci_seq;
    logic [3:0] busy_seq;
    ci_seq = '0;
    busy_seq = '0;
    bus.a = 4'b0101;
    bus.b = 4'b0011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      busy_seq[i] = bus.busy;
      ci_seq[i] = fa_ci;
      if (i == 0) begin
        tests_run++; if (fa_en !== 3'b100) begin tests_failed++; $display("FAIL basic_fa_en_run got=%b exp=100", fa_en); end
      end
      tick();
    end
    tests_run++; if (busy_seq !== 4'b1111) begin tests_failed++; $display("FAIL basic_busy_seq got=%b exp=1111", busy_seq); end
    tests_run++; if (ci_seq !== 4'b1110) begin tests_failed++; $display("FAIL basic_fa_ci_seq got=%b exp=1110 (0,1,1,1)", ci_seq); end
    tests_run++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
    tests_run++; if ({bus.cout, bus.sum, bus.err} !== {1'b0, 4'b1000, 1'b0}) begin tests_failed++; $display("FAIL basic_result got cout=%b sum=%b err=%b exp cout=0 sum=1000 err=0", bus.cout, bus.sum, bus.err); end
    tick();
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    $display("[TB] test_basic_add 0101+0011 sum=%b cout=%b", bus.sum, bus.cout);
  endtask

  task automatic test_overflow();
    int cyc;
    bus.a = 4'b1111;
    bus.b = 4'b0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL overflow_latency got=%0d exp=5", cyc); end
    tests_run++; if ({bus.cout, bus.sum, bus.err} !== {1'b1, 4'b0000, 1'b0}) begin tests_failed++; $display("FAIL overflow_result got cout=%b sum=%b err=%b exp cout=1 sum=0000 err=0", bus.cout, bus.sum, bus.err); end
    tick();
    $display("[TB] test_overflow 1111+0001 latency=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    int done_cyc[2];
    int n_done;
    n_done = 0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    bus.a = 4'b1010;
    bus.b = 4'b0110;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 20 && n_done < 2; cyc++) begin
      tick();
      // Scramble operands while a run is in flight; they must be ignored.
      if (cyc == 2 || cyc == 8) begin
        bus.a = 4'b1111;
        bus.b = 4'b1111;
      end
      if (bus.done === 1'b1) begin
        done_cyc[n_done] = cyc;
        tests_run++; if ({bus.cout, bus.sum} !== {1'b1, 4'b0000}) begin tests_failed++; $display("FAIL b2b_result%0d got cout=%b sum=%b exp cout=1 sum=0000", n_done, bus.cout, bus.sum); end
        n_done++;
        bus.a = 4'b1010;
        bus.b = 4'b0110;
        if (n_done == 2) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    tests_run++; if (n_done != 2) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    tests_run++; if (done_cyc[1] - done_cyc[0] != 6) begin tests_failed++; $display("FAIL b2b_period got=%0d exp=6", done_cyc[1] - done_cyc[0]); end
    tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_after got busy=%b exp=0", bus.busy); end
    tick();
    $display("[TB] test_back_to_back done at cycles %0d,%0d", done_cyc[0], done_cyc[1]);
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    int cyc;
    seen_done = 0;
    bus.a = 4'b0101;
    bus.b = 4'b0011;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    tests_run++; if ({bus.cout, bus.sum} !== 5'b0) begin tests_failed++; $display("FAIL rstmid_result got cout=%b sum=%b exp 0/0000", bus.cout, bus.sum); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    tests_run++; if (seen_done != 0) begin tests_failed++; $display("FAIL rstmid_no_activity got=%0d exp=0", seen_done); end
    bus.a = 4'd3;
    bus.b = 4'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL rstmid_latency got=%0d exp=5", cyc); end
    tests_run++; if ({bus.cout, bus.sum, bus.err} !== {1'b0, 4'd7, 1'b0}) begin tests_failed++; $display("FAIL rstmid_result2 got cout=%b sum=%0d err=%b exp cout=0 sum=7 err=0", bus.cout, bus.sum, bus.err); end
    tick();
    $display("[TB] test_reset_mid_run 3+4 sum=%0d", bus.sum);
  endtask

  task automatic test_fault();
    int cyc;
    fault_en = 1'b1;
    bus.a = 4'b0010;
    bus.b = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL fault_done got=%b exp=1", bus.done); end
    tests_run++; if ({bus.cout, bus.sum} !== {1'b0, 4'b0000}) begin tests_failed++; $display("FAIL fault_sum got cout=%b sum=%b exp cout=0 sum=0000", bus.cout, bus.sum); end
    tests_run++; if (bus.err !== 1'b1) begin tests_failed++; $display("FAIL fault_err got=%b exp=1", bus.err); end
    tick();
    fault_en = 1'b0;
    $display("[TB] test_fault 0010+0000 stuck bit1 sum=%b err=%b", bus.sum, bus.err);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one external decoder-based 1-bit full-adder slice (3-to-8 decoder with E1/E2_low/E3_low enables, Si/Ci outputs) to add two WIDTH-bit operands bit-serially, LSB first.
- Replaces a WIDTH-slice ripple chain with one slice plus a carry register.
- Provides a start/busy/done handshake.
- Cross-checks the serial result against a direct sum to flag a faulty slice.

Parameters:
WIDTH, 4, operand/sum width in bits (2..16)
IDXW, 4, bit-index counter width; must satisfy 2**IDXW >= WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
sum  output  WIDTH  registered result; held until next accepted start
cout  output  1  registered final carry
err  output  1  registered; set with done if {cout,sum} != a+b (captured operands)
fa_a  output  1  slice input A (decoder address bit 2)
fa_b  output  1  slice input B (decoder address bit 1)
fa_ci  output  1  slice carry-in (decoder address bit 0)
fa_en  output  3  slice enables {E1,E2_low,E3_low}
fa_s  input  1  slice sum (combinational from fa_a/fa_b/fa_ci)
fa_co  input  1  slice carry-out (combinational)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, idx=0, carry=0, operand registers=0.
- fa_a/fa_b/fa_ci: driven 0 outside RUN.
- fa_en: 3'b100 (slice enabled) in RUN; 3'b011 (disabled) otherwise.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch a→ra and b→rb; idx←0, carry←0; go to RUN.
  - sum, cout and err are not cleared on start; they keep old values until DONE.
- RUN (exactly WIDTH cycles):
  - Combinational drive: fa_a=ra[idx], fa_b=rb[idx], fa_ci=carry.
  - At each clock edge: sumr[idx]←fa_s, carry←fa_co, idx←idx+1.
  - When idx==WIDTH-1: go to DONE.
  - fa_s/fa_co are consumed in the same cycle; no added slice latency.
- DONE (one cycle):
  - done=1.
  - sum, cout and err take their values on the edge entering DONE: sum←sumr with final bit, cout←final carry, err←({final carry,sumr}!=ra+rb).
  - Next state IDLE unconditionally.
- Latency: start sampled at edge N → busy high in cycles N+1..N+WIDTH → done high in cycle N+WIDTH+1. Back-to-back start is accepted at earliest in the cycle after done (IDLE).
- start while busy or done: ignored, not queued.
- Operand changes after acceptance have no effect.
- rst mid-RUN/DONE: next cycle IDLE with all reset values; the partial result is discarded and done does not pulse.
- rst and start in the same cycle: rst wins.
- Wrap-around: sum is modulo 2**WIDTH; overflow is reported only in cout.
- err is diagnostic only. It is updated with each done and has no effect on sequencing.

Test Plan:
1. WIDTH=4, rst 2 cycles → busy=0, done=0, sum=0, cout=0, err=0, fa_en=3'b011.
2. Start with a=4'b0101, b=4'b0011, behavioural slice model → busy for 4 cycles; done one cycle later with sum=4'b1000, cout=0, err=0. Check fa_ci sequence per RUN cycle = 0,1,1,1.
3. a=4'b1111, b=4'b0001 → sum=4'b0000, cout=1, err=0; done exactly 5 cycles after start.
4. Hold start high continuously, a=4'b1010, b=4'b0110 → one done per 6 cycles (start re-accepted in IDLE), sum=4'b0000, cout=1. Operand change mid-RUN → no effect.
5. Assert rst in RUN cycle 2 → next cycle IDLE, busy=0, no done pulse, sum/cout=0. A following start with a=3, b=4 → sum=7, cout=0.
6. Fault model: slice fa_s stuck-at-0 on bit 1, a=4'b0010, b=4'b0000 → sum=4'b0000, err=1 with done.
